svc_rv_demo_runner: RTL and testbench

Parametrised run controller for RISC-V SoC demos. It sits beside an svc_rv_soc_* instance and sequences the SoC's reset. It counts cycles from reset release to ebreak and enforces a timeout watchdog. It also captures program results written to a memory-mapped mailbox on the SoC io bus, and reports pass/fail against an expected value. Demo tops and FPGA boards use it to rerun programs and read results back without a debugger.

---
 rtl/svc_rv_demo_pkg.sv | 15 +
 rtl/svc_rv_demo_mailbox.sv | 80 ++++++++
 rtl/svc_rv_demo_runner.sv | 130 +++++++++++++
 tb/tb_svc_rv_demo_runner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/svc_rv_demo_pkg.sv
// Shared types and constants for the RISC-V demo run controller.
package svc_rv_demo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    // Byte distance between consecutive mailbox words.
    localparam int MAILBOX_STRIDE = 4;

endpackage

// File: rtl/svc_rv_demo_mailbox.sv
// Result mailbox: byte-strobed capture of io-bus writes into NUM_RESULTS
// words, per-word written flags, and a registered read port.
module svc_rv_demo_mailbox
    import svc_rv_demo_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NUM_RESULTS  = 4,
    parameter logic [XLEN-1:0] MAILBOX_BASE = 32'h0000_0100,
    localparam int             IDX_W        = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   cap_en_i,
    input  logic                   io_wen_i,
    input  logic [XLEN-1:0]        io_waddr_i,
    input  logic [XLEN-1:0]        io_wdata_i,
    input  logic [XLEN/8-1:0]      io_wstrb_i,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic [XLEN-1:0]        rd_data_o,
    output logic [NUM_RESULTS-1:0] valid_o,
    output logic [XLEN-1:0]        word0_d_o,
    output logic                   valid0_d_o
);

    localparam logic [XLEN-1:0] SPAN = XLEN'(MAILBOX_STRIDE * NUM_RESULTS);

    logic [NUM_RESULTS-1:0][XLEN-1:0] mem_q, mem_d;
    logic [NUM_RESULTS-1:0]           valid_q, valid_d;
    logic [XLEN-1:0]                  rd_q, rd_d;
    logic [XLEN-1:0]                  off;
    logic                             hit;

    // Address decode and byte merge; clear has priority over capture.
    always_comb begin
        off     = io_waddr_i - MAILBOX_BASE;
        hit     = cap_en_i && io_wen_i && (io_waddr_i[1:0] == 2'b00) &&
                  (io_waddr_i >= MAILBOX_BASE) && (off < SPAN);
        mem_d   = mem_q;
        valid_d = valid_q;
        if (clr_i) begin
            mem_d   = '0;
            valid_d = '0;
        end else if (hit) begin
            for (int w = 0; w < NUM_RESULTS; w++) begin
                if (off[XLEN-1:2] == (XLEN-2)'(w)) begin
                    valid_d[w] = 1'b1;
                    for (int b = 0; b < XLEN/8; b++) begin
                        if (io_wstrb_i[b]) mem_d[w][8*b +: 8] = io_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read mux from current contents, so a same-cycle write returns old data.
    always_comb begin
        rd_d = '0;
        if (int'(rd_idx_i) < NUM_RESULTS) rd_d = mem_q[rd_idx_i];
    end

    // Mailbox storage and read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            valid_q <= '0;
            rd_q    <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    assign rd_data_o  = rd_q;
    assign valid_o    = valid_q;
    assign word0_d_o  = mem_d[0];
    assign valid0_d_o = valid_d[0];

endmodule

// File: rtl/svc_rv_demo_runner.sv
// Demo run controller: sequences SoC reset, counts RUN cycles to ebreak,
// enforces a watchdog and reports mailbox results with a pass flag.
module svc_rv_demo_runner
    import svc_rv_demo_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              NUM_RESULTS  = 4,
    parameter logic [XLEN-1:0] MAILBOX_BASE = 32'h0000_0100,
    parameter int              CYCLE_W      = 32,
    parameter int              TIMEOUT      = 100000,
    parameter int              RST_HOLD     = 4,
    parameter logic [XLEN-1:0] EXPECT0      = 32'h0,
    localparam int             IDX_W        = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    output logic                   soc_rst_n_o,
    input  logic                   soc_ebreak_i,
    input  logic                   io_wen_i,
    input  logic [XLEN-1:0]        io_waddr_i,
    input  logic [XLEN-1:0]        io_wdata_i,
    input  logic [XLEN/8-1:0]      io_wstrb_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic                   pass_o,
    output logic [CYCLE_W-1:0]     cycles_o,
    output logic [NUM_RESULTS-1:0] result_valid_o,
    input  logic [IDX_W-1:0]       rd_idx_i,
    output logic [XLEN-1:0]        rd_data_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d, cyc_inc;
    logic               pass_q;
    logic               clr, wd_hit;
    logic [XLEN-1:0]    word0_d;
    logic               valid0_d;

    // State, hold counter and cycle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cycles_q <= cycles_d;
        end
    end

    // Next-state logic; ebreak takes priority over the watchdog.
    always_comb begin
        cyc_inc  = (cycles_q == '1) ? cycles_q : cycles_q + 1'b1;
        wd_hit   = (TIMEOUT != 0) && (cycles_q == CYCLE_W'(TIMEOUT - 1));
        clr      = 1'b0;
        state_d  = state_q;
        hold_d   = hold_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_i) begin
                    clr      = 1'b1;
                    state_d  = ST_HOLD;
                    hold_d   = '0;
                    cycles_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_RUN;
                else                                 hold_d  = hold_q + 1'b1;
            end
            ST_RUN: begin
                if (soc_ebreak_i) begin
                    state_d  = ST_DONE;
                    cycles_d = cyc_inc;
                end else if (wd_hit) begin
                    state_d  = ST_TIMEOUT;
                end else begin
                    cycles_d = cyc_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; the SoC only leaves reset while running.
    always_comb begin
        soc_rst_n_o = (state_q == ST_RUN);
        busy_o      = (state_q == ST_HOLD) || (state_q == ST_RUN);
        done_o      = (state_q == ST_DONE);
        timeout_o   = (state_q == ST_TIMEOUT);
    end

    // Pass looks at next-cycle mailbox contents so a write coinciding with
    // ebreak is reflected from the first DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) pass_q <= 1'b0;
        else     pass_q <= (state_d == ST_DONE) && valid0_d && (word0_d == EXPECT0);
    end

    assign pass_o   = pass_q;
    assign cycles_o = cycles_q;

    svc_rv_demo_mailbox #(
        .XLEN        (XLEN),
        .NUM_RESULTS (NUM_RESULTS),
        .MAILBOX_BASE(MAILBOX_BASE)
    ) u_mailbox (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .cap_en_i  (state_q == ST_RUN),
        .io_wen_i  (io_wen_i),
        .io_waddr_i(io_waddr_i),
        .io_wdata_i(io_wdata_i),
        .io_wstrb_i(io_wstrb_i),
        .rd_idx_i  (rd_idx_i),
        .rd_data_o (rd_data_o),
        .valid_o   (result_valid_o),
        .word0_d_o (word0_d),
        .valid0_d_o(valid0_d)
    );

endmodule

// File: tb/tb_svc_rv_demo_runner.sv
// Directed bench: instance A (EXPECT0=0x3D, long watchdog) covers run,
// mailbox, pass and reset; instance B (TIMEOUT=20) covers the watchdog.
module tb_svc_rv_demo_runner;

    logic        clk = 1'b0;
    logic        rst, start, ebreak, wen;
    logic [31:0] waddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  rd_idx;

    logic        a_rst_n, a_busy, a_done, a_to, a_pass;
    logic [31:0] a_cyc, a_rd;
    logic [3:0]  a_val;
    logic        b_rst_n, b_busy, b_done, b_to, b_pass;
    logic [31:0] b_cyc, b_rd;
    logic [3:0]  b_val;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    svc_rv_demo_runner #(.TIMEOUT(100000), .EXPECT0(32'h0000_003D)) u_a (
        .clk(clk), .rst(rst), .start_i(start), .soc_rst_n_o(a_rst_n),
        .soc_ebreak_i(ebreak), .io_wen_i(wen), .io_waddr_i(waddr),
        .io_wdata_i(wdata), .io_wstrb_i(wstrb), .busy_o(a_busy),
        .done_o(a_done), .timeout_o(a_to), .pass_o(a_pass), .cycles_o(a_cyc),
        .result_valid_o(a_val), .rd_idx_i(rd_idx), .rd_data_o(a_rd)
    );

    svc_rv_demo_runner #(.TIMEOUT(20)) u_b (
        .clk(clk), .rst(rst), .start_i(start), .soc_rst_n_o(b_rst_n),
        .soc_ebreak_i(ebreak), .io_wen_i(wen), .io_waddr_i(waddr),
        .io_wdata_i(wdata), .io_wstrb_i(wstrb), .busy_o(b_busy),
        .done_o(b_done), .timeout_o(b_to), .pass_o(b_pass), .cycles_o(b_cyc),
        .result_valid_o(b_val), .rd_idx_i(rd_idx), .rd_data_o(b_rd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wen = 1'b1; waddr = a; wdata = d; wstrb = s;
        step();
        wen = 1'b0;
    endtask

    // start pulse then RST_HOLD cycles, leaving us in the first RUN cycle
    task automatic launch();
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ebreak = 1'b0; wen = 1'b0;
        waddr = '0; wdata = '0; wstrb = '0; rd_idx = '0;
        step(); step(); rst = 1'b0; step();

        // reset state
        chk("rst_soc_rst_n", a_rst_n, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_timeout", a_to, 0);
        chk("rst_pass", a_pass, 0);
        chk("rst_cycles", a_cyc, 0);
        chk("rst_valid", a_val, 0);
        chk("rst_rd_data", a_rd, 0);

        // basic run: SoC held exactly 4 cycles after start
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_soc_rst_n", a_rst_n, 0);
            step();
        end
        chk("run_soc_rst_n", a_rst_n, 1);
        chk("run_busy", a_busy, 1);

        // mailbox capture, misaligned and out-of-range writes dropped
        wr(32'h100, 32'hDEADBEEF, 4'hF);
        wr(32'h10C, 32'h000000AA, 4'h1);
        wr(32'h102, 32'h11111111, 4'hF);
        wr(32'h110, 32'h22222222, 4'hF);
        chk("mb_valid", a_val, 4'b1001);
        rd_idx = 2'd0; step(); chk("mb_rd0", a_rd, 32'hDEADBEEF);
        rd_idx = 2'd3; step(); chk("mb_rd3", a_rd, 32'h000000AA);
        rd_idx = 2'd1; step(); chk("mb_rd1", a_rd, 32'h0);
        chk("run_cycles7", a_cyc, 7);

        repeat (42) step();
        ebreak = 1'b1; step(); ebreak = 1'b0;
        chk("basic_done", a_done, 1);
        chk("basic_cycles", a_cyc, 50);
        chk("basic_timeout", a_to, 0);
        chk("basic_soc_rst_n", a_rst_n, 0);
        chk("basic_busy", a_busy, 0);
        chk("basic_pass", a_pass, 0);

        // writes after DONE ignored, counters held
        wr(32'h104, 32'h55555555, 4'hF);
        step();
        chk("done_valid_held", a_val, 4'b1001);
        chk("done_cycles_held", a_cyc, 50);

        // rerun clears state; start in RUN ignored
        start = 1'b1; step(); start = 1'b0;
        chk("rerun_valid", a_val, 0);
        chk("rerun_cycles", a_cyc, 0);
        chk("rerun_busy", a_busy, 1);
        chk("rerun_done", a_done, 0);
        repeat (4) step();
        chk("rerun_soc_rst_n", a_rst_n, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("run_start_ignored", a_rst_n, 1);
        chk("run_start_cycles", a_cyc, 1);

        // byte-merged 0x3D with ebreak in the same cycle; read sees old value
        rd_idx = 2'd0; waddr = 32'h100; wdata = 32'hFFFFFF3D; wstrb = 4'h1;
        wen = 1'b1; ebreak = 1'b1; step(); wen = 1'b0; ebreak = 1'b0;
        chk("pass_done", a_done, 1);
        chk("pass_pass", a_pass, 1);
        chk("pass_cycles", a_cyc, 2);
        chk("pass_rd_old", a_rd, 0);
        chk("pass_b_expect0", b_pass, 0);
        step();
        chk("pass_rd_new", a_rd, 32'h0000003D);

        // wrong value -> no pass
        launch();
        waddr = 32'h100; wdata = 32'h0000003C; wstrb = 4'hF;
        wen = 1'b1; ebreak = 1'b1; step(); wen = 1'b0; ebreak = 1'b0;
        chk("fail_done", a_done, 1);
        chk("fail_pass", a_pass, 0);

        // watchdog on instance B
        launch();
        repeat (19) step();
        chk("wd_pre_timeout", b_to, 0);
        chk("wd_pre_busy", b_busy, 1);
        step();
        chk("wd_timeout", b_to, 1);
        chk("wd_cycles", b_cyc, 19);
        chk("wd_soc_rst_n", b_rst_n, 0);
        chk("wd_done", b_done, 0);

        // ebreak on the limit cycle wins
        launch();
        repeat (19) step();
        ebreak = 1'b1; step(); ebreak = 1'b0;
        chk("wdlim_done", b_done, 1);
        chk("wdlim_timeout", b_to, 0);
        chk("wdlim_cycles", b_cyc, 20);

        // reset mid-run
        launch();
        wr(32'h100, 32'h12345678, 4'hF);
        rd_idx = 2'd0;
        repeat (9) step();
        chk("mid_busy", a_busy, 1);
        chk("mid_rd", a_rd, 32'h12345678);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_soc_rst_n", a_rst_n, 0);
        chk("mrst_busy", a_busy, 0);
        chk("mrst_done", a_done, 0);
        chk("mrst_timeout", a_to, 0);
        chk("mrst_pass", a_pass, 0);
        chk("mrst_cycles", a_cyc, 0);
        chk("mrst_valid", a_val, 0);
        chk("mrst_rd", a_rd, 0);
        chk("mrst_b_valid", b_val, 0);
        chk("mrst_b_rd", b_rd, 0);
        step();
        chk("idle_busy", a_busy, 0);
        chk("idle_soc_rst_n", a_rst_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
